if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction fetch stage. It produces the {pc_four, instruction} pair consumed by the IF/ID pipeline register.
- Owns the fetch PC.
- Issues variable-latency requests on the instruction-memory handshake.
- Buffers returned words in a small FIFO so a decode stall never loses a fetched instruction.
- Honours branch/jump redirects from EX, discarding in-flight and buffered wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
BUF_DEPTH, 2, fetch-buffer entries (power of 2, >=2)
NOP_WORD, 32'h0000_0000, instruction value presented when buffer empty

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
stall  input  1  same signal driving IF/ID stall; 1 = downstream not consuming
redirect  input  1  branch/jump taken; one-cycle pulse
redirect_pc  input  32  new fetch address, valid with redirect
imem_req  output  1  request valid
imem_addr  output  32  word-aligned fetch address, stable while imem_req high
imem_ack  input  1  request complete, imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction
pc_four  output  32  PC+4 of instruction at buffer head
instruction  output  32  buffer head, NOP_WORD when empty
inst_valid  output  1  buffer non-empty

Behaviour:
Clock and reset:
- Single clock domain (clk); rst_n is asynchronous, active-low.

Reset values:
- fetch_pc = RESET_PC; FSM = IDLE; buffer empty; imem_req = 0; imem_addr = RESET_PC; drop = 0.
- Resulting outputs: inst_valid = 0, instruction = NOP_WORD, pc_four = RESET_PC + 4.
- Reset mid-transaction abandons the request. The memory model must tolerate a withdrawn imem_req.

FSM states:
- IDLE: imem_req = 0. Go to BUSY when count + 0 < BUF_DEPTH and redirect = 0.
- BUSY: imem_req = 1, imem_addr = fetch_pc. On imem_ack:
  - push {fetch_pc+4, imem_rdata}; fetch_pc += 4.
  - Back-to-back: stay in BUSY (new address next cycle) if space remains after this push and pop, else go to IDLE.
- DISCARD: imem_req = 1, imem_addr = stale address held. On imem_ack: drop the data, fetch_pc unchanged (already redirected), go to IDLE.

Request rules:
- At most one outstanding request.
- imem_req and imem_addr are never changed before imem_ack (no withdrawal except reset).
- Ack is accepted in the same cycle as first assertion of imem_req.

Pop:
- On posedge with stall = 0 and inst_valid = 1, the head is consumed. IF/ID captures it on the same edge.
- instruction and pc_four are combinational from the buffer head; no extra latency.
- Fetch-to-IF/ID latency with empty buffer: ack cycle N → visible combinationally from N+1 → captured at end of N+1.

Redirect (highest priority):
- Buffer cleared; fetch_pc <= redirect_pc.
- In BUSY without ack this cycle: go to DISCARD.
- In BUSY with ack this cycle: data discarded, go to IDLE.
- In DISCARD: stay in DISCARD; fetch_pc updated to latest redirect_pc.
- In IDLE: stay in IDLE, request next cycle.
- Pop in the same cycle is ignored.

Simultaneous push and pop:
- Allowed when full; count unchanged.
- Push into a full buffer cannot occur: a request is issued only when a slot is guaranteed.

Arithmetic and alignment:
- PC arithmetic mod 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- redirect_pc[1:0] ignored (forced 00).

Stall:
- stall = 1 indefinitely: buffer fills to BUF_DEPTH, then FSM idles. No data lost, no duplicates.

Decomposition:
Shared package if_pkg:
- NOP_WORD and RESET_PC constants.
- fetch FSM state encoding (IDLE = 2'd0, BUSY = 2'd1, DISCARD = 2'd2).
- fetch-entry struct {pc_four[31:0], instr[31:0]}.

Sub-module: if_fetch_buffer
- Synchronous FIFO, BUF_DEPTH x 64 bits.
- Signals: push, pop, clear, count, full, empty.
- clear has priority over push and pop.

Test Plan:
1. Reset release, ack latency 1, stall = 0 → imem_addr sequence 0,4,8,…; instruction stream matches memory; pc_four = 4,8,12 on successive consumed cycles.
2. stall = 1 for 10 cycles, mem at addr 0x10 = 0xAAAA0001, 0x14 = 0xAAAA0002 → buffer holds 2, imem_req drops to 0. Release stall → 0xAAAA0001 then 0xAAAA0002 consumed in order, no gap beyond one refetch cycle.
3. Ack latency 3, redirect to 0x100 one cycle after request to 0x20 → 0x20 ack data dropped; next imem_addr = 0x100; first valid instruction has pc_four = 0x104.
4. Redirect to 0x200 coincident with imem_ack for 0x40 → 0x40 data not pushed; buffer empty next cycle; next request 0x200.
5. Redirect while buffer full and stall = 1 → inst_valid = 0 next cycle; only redirect-path instructions appear afterwards.
6. RESET_PC = 32'hFFFF_FFFC → first pc_four = 0, second imem_addr = 0. Assert rst_n = 0 mid-BUSY → imem_req falls asynchronously; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] IF_NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc_four;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_buffer.sv
// Small synchronous FIFO holding fetched {pc_four, instr} words until decode consumes them.
module if_fetch_buffer
    import if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [63:0]              wr_data,
    output logic [63:0]              head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // Clear wins over push and pop so a redirect leaves nothing from the old path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= wr_data;
    end

    assign head_data = mem[rd_ptr];
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, issues one-at-a-time memory requests and buffers the results.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = IF_RESET_PC,
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] NOP_WORD  = IF_NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_four,
    output logic [31:0] instruction,
    output logic        inst_valid
);

    localparam int                CW      = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0]     DEPTH_C = CW'(BUF_DEPTH);

    fetch_state_t  state, state_nxt;
    logic [31:0]   fetch_pc, fetch_pc_nxt, stale_addr;
    logic          push, pop, full, empty;
    logic [CW-1:0] count, count_after;
    logic [63:0]   head_data;
    fetch_entry_t  head, push_entry;

    assign push_entry.pc_four = fetch_pc + 32'd4;
    assign push_entry.instr   = imem_rdata;
    assign head               = head_data;

    // A redirect in the same cycle kills the pop: the head belongs to the wrong path.
    assign pop         = !stall && !empty && !redirect;
    assign inst_valid  = !empty;
    assign instruction = empty ? NOP_WORD : head.instr;
    assign pc_four     = empty ? fetch_pc + 32'd4 : head.pc_four;

    if_fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .clear     (redirect),
        .wr_data   (push_entry),
        .head_data (head_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            stale_addr <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            if (state == BUSY) stale_addr <= fetch_pc;
        end
    end

    // DISCARD keeps presenting the abandoned address until memory completes it.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        push         = 1'b0;
        imem_req     = 1'b0;
        imem_addr    = fetch_pc;
        case (state)
            IDLE: begin
                if (!redirect && !full) state_nxt = BUSY;
            end
            BUSY: begin
                imem_req = 1'b1;
                if (redirect) begin
                    state_nxt = imem_ack ? IDLE : DISCARD;
                end else if (imem_ack) begin
                    push         = 1'b1;
                    fetch_pc_nxt = fetch_pc + 32'd4;
                end
            end
            DISCARD: begin
                imem_req  = 1'b1;
                imem_addr = stale_addr;
                if (imem_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        count_after = count + CW'(push) - CW'(pop);
        if (push) state_nxt = (count_after < DEPTH_C) ? BUSY : IDLE;
        if (redirect) fetch_pc_nxt = redirect_pc & ~32'd3;
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: expected program-order stream is queued when a path starts.
module tb_if_fetch_unit;
    import if_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata, pc_four, instruction;
    logic        inst_valid;

    logic        rst_n_w;
    logic        stall_w = 1'b0, redirect_w = 1'b0;
    logic [31:0] redirect_pc_w = 32'h0;
    logic        imem_req_w, imem_ack_w, inst_valid_w;
    logic [31:0] imem_addr_w, imem_rdata_w, pc_four_w, instruction_w;

    int vec_count = 0;
    int miss_count = 0;
    int consumed = 0;
    int ack_lat = 1;
    int wcnt;

    fetch_entry_t exp_q[$];
    fetch_entry_t mon_e;
    logic [31:0]  ack_log[$];
    logic [31:0]  log_w[$];
    logic         hold_prev = 1'b0;
    logic [31:0]  prev_addr;
    logic         w_seen = 1'b0;
    logic [31:0]  w_pc_four, w_instr;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc_four(pc_four), .instruction(instruction), .inst_valid(inst_valid)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n_w), .stall(stall_w), .redirect(redirect_w), .redirect_pc(redirect_pc_w),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w),
        .pc_four(pc_four_w), .instruction(instruction_w), .inst_valid(inst_valid_w)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'h10:  return 32'hAAAA_0001;
            32'h14:  return 32'hAAAA_0002;
            default: return {~a[15:0] ^ a[31:16], a[15:0]};
        endcase
    endfunction

    // Variable-latency memory: ack arrives in the ack_lat-th cycle a request is held.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt <= 0;
        else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end
    assign imem_ack     = imem_req && (wcnt >= ack_lat - 1);
    assign imem_rdata   = imem_ack ? memWord(imem_addr) : 32'hDEAD_BEEF;
    assign imem_ack_w   = imem_req_w;
    assign imem_rdata_w = memWord(imem_addr_w);

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic newPath(input logic [31:0] start);
        fetch_entry_t e;
        exp_q.delete();
        for (int i = 0; i < 48; i++) begin
            e.pc_four = start + 32'(4 * (i + 1));
            e.instr   = memWord(start + 32'(4 * i));
            exp_q.push_back(e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic [31:0] pc);
        stall       = s;
        redirect    = r;
        redirect_pc = pc;
        if (r) newPath(pc & ~32'd3);
    endtask

    task automatic waitConsumed(input int n, input int budget);
        int start;
        int k;
        start = consumed;
        k = 0;
        while ((consumed - start) < n && k < budget) begin
            tick(1);
            k++;
        end
        checkOutput("progress", 32'((consumed - start) >= n), 32'd1);
    endtask

    task automatic waitReqAddr(input logic [31:0] addr, input int budget);
        int k;
        k = 0;
        do begin
            tick(1);
            k++;
        end while (!(imem_req && imem_addr == addr) && k < budget);
        checkOutput("req_seen", imem_addr, addr);
    endtask

    function automatic logic [31:0] logAt(input int i);
        if (i < ack_log.size()) return ack_log[i];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] logAtW(input int i);
        if (i < log_w.size()) return log_w[i];
        return 32'hFFFF_FFFF;
    endfunction

    // Consumption is checked in program order; request address must hold until acked.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!stall && !redirect && inst_valid) begin
                checkOutput("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    checkOutput("instr", instruction, mon_e.instr);
                    checkOutput("pc_four", pc_four, mon_e.pc_four);
                end
                consumed++;
            end
            if (imem_req && imem_ack) ack_log.push_back(imem_addr);
            if (hold_prev) begin
                checkOutput("req_hold", 32'(imem_req), 32'd1);
                checkOutput("addr_hold", imem_addr, prev_addr);
            end
            hold_prev = imem_req && !imem_ack;
            prev_addr = imem_addr;
        end else begin
            hold_prev = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n_w) begin
            if (imem_req_w && imem_ack_w) log_w.push_back(imem_addr_w);
            if (inst_valid_w && !w_seen) begin
                w_seen    = 1'b1;
                w_pc_four = pc_four_w;
                w_instr   = instruction_w;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rst_n_w = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        #12;
        checkOutput("rst_valid", 32'(inst_valid), 32'd0);
        checkOutput("rst_instr", instruction, 32'h0);
        checkOutput("rst_pc_four", pc_four, 32'h4);
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_addr", imem_addr, 32'h0);
        checkOutput("rst_pc_four_w", pc_four_w, 32'h0);
        checkOutput("rst_addr_w", imem_addr_w, 32'hFFFF_FFFC);

        // Streaming from reset with single-cycle memory.
        newPath(32'h0);
        ack_log.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rst_n_w = 1'b1;
        waitConsumed(6, 40);
        for (int i = 0; i < 4; i++) checkOutput("t1_addr", logAt(i), 32'(4 * i));

        // Stall fills the buffer from 0x10, then drains in order.
        applyStimulus(1'b1, 1'b1, 32'h10);
        tick(1);
        redirect = 1'b0;
        tick(9);
        checkOutput("t2_req_idle", 32'(imem_req), 32'd0);
        checkOutput("t2_valid", 32'(inst_valid), 32'd1);
        checkOutput("t2_head", instruction, 32'hAAAA_0001);
        checkOutput("t2_pc_four", pc_four, 32'h14);
        applyStimulus(1'b0, 1'b0, 32'h0);
        waitConsumed(4, 20);

        // Redirect one cycle into a slow request: its data must be dropped.
        ack_lat = 3;
        applyStimulus(1'b0, 1'b1, 32'h20);
        tick(1);
        redirect = 1'b0;
        waitReqAddr(32'h20, 30);
        tick(1);
        ack_log.delete();
        applyStimulus(1'b0, 1'b1, 32'h102);
        tick(1);
        redirect = 1'b0;
        waitConsumed(3, 60);
        checkOutput("t3_stale_ack", logAt(0), 32'h20);
        checkOutput("t3_next_addr", logAt(1), 32'h100);

        // Redirect coincident with the ack.
        applyStimulus(1'b0, 1'b1, 32'h40);
        tick(1);
        redirect = 1'b0;
        waitReqAddr(32'h40, 30);
        tick(2);
        checkOutput("t4_ack_now", 32'(imem_ack), 32'd1);
        applyStimulus(1'b0, 1'b1, 32'h200);
        tick(1);
        redirect = 1'b0;
        ack_log.delete();
        checkOutput("t4_empty", 32'(inst_valid), 32'd0);
        checkOutput("t4_req_idle", 32'(imem_req), 32'd0);
        waitConsumed(2, 60);
        checkOutput("t4_next_addr", logAt(0), 32'h200);

        // Redirect while full and stalled clears the buffer.
        ack_lat = 1;
        applyStimulus(1'b1, 1'b1, 32'h300);
        tick(1);
        redirect = 1'b0;
        tick(6);
        checkOutput("t5_req_idle", 32'(imem_req), 32'd0);
        checkOutput("t5_full_valid", 32'(inst_valid), 32'd1);
        applyStimulus(1'b1, 1'b1, 32'h400);
        tick(1);
        redirect = 1'b0;
        checkOutput("t5_cleared", 32'(inst_valid), 32'd0);
        tick(5);
        checkOutput("t5_head", instruction, memWord(32'h400));
        checkOutput("t5_head_pc", pc_four, 32'h404);
        applyStimulus(1'b0, 1'b0, 32'h0);
        waitConsumed(4, 30);

        // Wrapping reset PC and reset in the middle of a request.
        checkOutput("t6_w_first_seen", 32'(w_seen), 32'd1);
        checkOutput("t6_w_pc_four", w_pc_four, 32'h0);
        checkOutput("t6_w_instr", w_instr, memWord(32'hFFFF_FFFC));
        checkOutput("t6_w_addr0", logAtW(0), 32'hFFFF_FFFC);
        checkOutput("t6_w_addr1", logAtW(1), 32'h0);
        ack_lat = 3;
        begin
            int k;
            k = 0;
            do begin
                tick(1);
                k++;
            end while (!imem_req && k < 20);
        end
        checkOutput("t6_busy", 32'(imem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_req_async", 32'(imem_req), 32'd0);
        checkOutput("t6_rst_valid", 32'(inst_valid), 32'd0);
        checkOutput("t6_rst_addr", imem_addr, 32'h0);
        tick(2);
        newPath(32'h0);
        ack_log.delete();
        rst_n = 1'b1;
        waitConsumed(3, 60);
        checkOutput("t6_restart_addr", logAt(0), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
